// File: rtl/imc_pkg.sv
// Shared types and default sizing for the bit-serial IMC multiplier sequencer.
package imc_pkg;

    localparam int IMC_N_ROWS  = 16;
    localparam int IMC_ACT_W   = 8;
    localparam int IMC_MUL_LAT = 1;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        DONE
    } ctrl_state_t;

    // Slice-time accumulator controls, aligned to the multiplier output by the delay pipe.
    typedef struct packed {
        logic en;
        logic clear;
        logic neg;
        logic last;
    } acc_ctrl_t;

    localparam acc_ctrl_t ACC_CTRL_NONE = '0;

endpackage

// File: rtl/imc_ctrl_delay.sv
// Fixed-depth register pipe that delays accumulator controls by the multiplier latency.
module imc_ctrl_delay
    import imc_pkg::*;
#(
    parameter int DEPTH = IMC_MUL_LAT
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      flush,
    input  acc_ctrl_t d,
    output acc_ctrl_t q
);

    acc_ctrl_t pipe [DEPTH];

    // NOTE: every stage is reset (not just the tail) because a stale en/last bit would fire the accumulator.
    // NOTE: non-blocking assignments make each stage take the previous stage's pre-edge value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= ACC_CTRL_NONE;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= ACC_CTRL_NONE;
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign q = pipe[DEPTH-1];

endmodule

// File: rtl/imc_bitserial_ctrl.sv
// Sequencer: latches an activation vector, streams it MSB-first one bit-slice per cycle,
// and emits accumulator controls aligned to the registered multiplier output.
module imc_bitserial_ctrl
    import imc_pkg::*;
#(
    parameter  int N_ROWS  = IMC_N_ROWS,
    parameter  int ACT_W   = IMC_ACT_W,
    parameter  int MUL_LAT = IMC_MUL_LAT,
    localparam int IDX_W   = (ACT_W > 1) ? $clog2(ACT_W) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_valid,
    output logic                      start_ready,
    input  logic [N_ROWS*ACT_W-1:0]   act_in,
    input  logic                      act_signed,
    input  logic                      abort,
    output logic [N_ROWS-1:0]         slice_out,
    output logic                      slice_valid,
    output logic [IDX_W-1:0]          bit_idx,
    output logic                      acc_en,
    output logic                      acc_clear,
    output logic                      acc_neg,
    output logic                      acc_last,
    output logic                      busy,
    output logic                      done_valid,
    input  logic                      done_ready
);

    localparam int                CNT_W    = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [IDX_W-1:0]  IDX_MSB  = IDX_W'(ACT_W - 1);
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(MUL_LAT - 1);

    ctrl_state_t               state, state_nxt;
    logic [N_ROWS*ACT_W-1:0]   act_q;
    logic                      sign_q;
    logic [CNT_W-1:0]          drain_cnt;
    logic                      accept;
    logic                      kill;
    acc_ctrl_t                 ctrl_now;
    acc_ctrl_t                 ctrl_dly;

    // abort wins over a simultaneous start; in IDLE it has no other effect
    assign kill   = abort && (state != IDLE);
    assign accept = (state == IDLE) && start_valid && !abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_nxt   = state;
        start_ready = 1'b0;
        busy        = 1'b1;
        slice_valid = 1'b0;
        done_valid  = 1'b0;
        case (state)
            IDLE: begin
                start_ready = 1'b1;
                busy        = 1'b0;
                if (accept) state_nxt = STREAM;
            end
            STREAM: begin
                slice_valid = 1'b1;
                if (bit_idx == '0) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (drain_cnt == '0) state_nxt = DONE;
            end
            DONE: begin
                done_valid = 1'b1;
                if (done_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (kill) state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_q     <= '0;
            sign_q    <= 1'b0;
            bit_idx   <= '0;
            drain_cnt <= '0;
        end else begin
            if (accept) begin
                act_q   <= act_in;
                sign_q  <= act_signed;
                bit_idx <= IDX_MSB;
            end else if (state == STREAM && bit_idx != '0) begin
                bit_idx <= bit_idx - IDX_W'(1);
            end

            if (state == STREAM && bit_idx == '0)
                drain_cnt <= CNT_INIT;
            else if (state == DRAIN && drain_cnt != '0)
                drain_cnt <= drain_cnt - CNT_W'(1);
        end
    end

    // Zero slice outside STREAM so the multiplier sees no stray products.
    always_comb begin
        slice_out = '0;
        if (state == STREAM) begin
            for (int r = 0; r < N_ROWS; r++) slice_out[r] = act_q[r*ACT_W + int'(bit_idx)];
        end
    end

    always_comb begin
        ctrl_now = ACC_CTRL_NONE;
        if (state == STREAM) begin
            ctrl_now.en    = 1'b1;
            ctrl_now.clear = (bit_idx == IDX_MSB);
            ctrl_now.neg   = (bit_idx == IDX_MSB) && sign_q;
            ctrl_now.last  = (bit_idx == '0);
        end
    end

    imc_ctrl_delay #(
        .DEPTH (MUL_LAT)
    ) u_delay (
        .clk   (clk),
        .rst   (rst),
        .flush (kill),
        .d     (ctrl_now),
        .q     (ctrl_dly)
    );

    assign acc_en    = ctrl_dly.en;
    assign acc_clear = ctrl_dly.clear;
    assign acc_neg   = ctrl_dly.neg;
    assign acc_last  = ctrl_dly.last;

endmodule

// File: tb/tb_imc_bitserial_ctrl.sv
// Self-checking bench: table vectors, random vectors against a multiply/accumulate model,
// backpressure, abort and mid-vector reset, for MUL_LAT=1 and MUL_LAT=3 instances.
module tb_imc_bitserial_ctrl;

    localparam int N = 16;
    localparam int W = 8;

    typedef struct packed {
        logic         start_ready;
        logic [N-1:0] slice_out;
        logic         slice_valid;
        logic [2:0]   bit_idx;
        logic         acc_en;
        logic         acc_clear;
        logic         acc_neg;
        logic         acc_last;
        logic         busy;
        logic         done_valid;
    } obs_t;

    typedef struct {
        logic [N*W-1:0] act;
        logic           sgn;
        logic [W*N-1:0] exp_slices;   // slice for bit b at [b*N +: N]
    } vec_t;

    logic           clk = 1'b0;
    logic           rst1, rst3;
    logic           start_valid, act_signed, abort, done_ready;
    logic [N*W-1:0] act_in;
    logic           sel;
    obs_t           o1, o3, o;

    int     n_checks = 0;
    int     n_fail   = 0;
    int     lat;
    int     w [N];
    longint mulq [4];
    longint acc, acc_result;
    bit     got_result;
    vec_t   tbl [5];

    always #5 clk = ~clk;

    imc_bitserial_ctrl dut1 (
        .clk(clk), .rst(rst1), .start_valid(start_valid), .start_ready(o1.start_ready),
        .act_in(act_in), .act_signed(act_signed), .abort(abort),
        .slice_out(o1.slice_out), .slice_valid(o1.slice_valid), .bit_idx(o1.bit_idx),
        .acc_en(o1.acc_en), .acc_clear(o1.acc_clear), .acc_neg(o1.acc_neg), .acc_last(o1.acc_last),
        .busy(o1.busy), .done_valid(o1.done_valid), .done_ready(done_ready)
    );

    imc_bitserial_ctrl #(.MUL_LAT(3)) dut3 (
        .clk(clk), .rst(rst3), .start_valid(start_valid), .start_ready(o3.start_ready),
        .act_in(act_in), .act_signed(act_signed), .abort(abort),
        .slice_out(o3.slice_out), .slice_valid(o3.slice_valid), .bit_idx(o3.bit_idx),
        .acc_en(o3.acc_en), .acc_clear(o3.acc_clear), .acc_neg(o3.acc_neg), .acc_last(o3.acc_last),
        .busy(o3.busy), .done_valid(o3.done_valid), .done_ready(done_ready)
    );

    always_comb o = sel ? o3 : o1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (lat=%0d, t=%0t): got %0h expected %0h", name, lat, $time, got, exp);
        end
    endtask

    // Multiplier model: tree sum of weights on rows whose slice bit is set.
    function automatic longint tree_sum(input logic [N-1:0] s);
        longint t = 0;
        for (int r = 0; r < N; r++) if (s[r]) t += longint'(w[r]);
        return t;
    endfunction

    function automatic longint golden(input logic [N*W-1:0] a, input logic sgn);
        longint s = 0;
        for (int r = 0; r < N; r++) begin
            logic [W-1:0] v;
            longint x;
            v = a[r*W +: W];
            x = longint'(v);
            if (sgn && v[W-1]) x -= 256;
            s += longint'(w[r]) * x;
        end
        return s;
    endfunction

    function automatic logic [W*N-1:0] pack_slices(input logic [N*W-1:0] a);
        logic [W*N-1:0] p = '0;
        for (int b = 0; b < W; b++)
            for (int r = 0; r < N; r++) p[b*N + r] = a[r*W + b];
        return p;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) mulq[i] = 0;
        acc = 0;
    endfunction

    // Advance one cycle; sample the new cycle and step the multiplier/accumulator model.
    task automatic tick();
        logic   r;
        longint m;
        @(posedge clk);
        #1;
        r = sel ? rst3 : rst1;
        if (r) begin
            model_reset();
        end else begin
            m = mulq[lat-1];
            if (o.acc_en) begin
                if (o.acc_neg) m = -m;
                acc = o.acc_clear ? m : 2 * acc + m;
                if (o.acc_last) begin
                    acc_result = acc;
                    got_result = 1'b1;
                end
            end
            for (int i = 3; i > 0; i--) mulq[i] = mulq[i-1];
            mulq[0] = tree_sum(o.slice_out);
        end
    endtask

    task automatic set_rst(input logic v);
        if (sel) rst3 = v;
        else     rst1 = v;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " start_ready"}, 32'(o.start_ready), 32'd1);
        check({tag, " busy"},        32'(o.busy),        32'd0);
        check({tag, " slice_valid"}, 32'(o.slice_valid), 32'd0);
        check({tag, " slice_out"},   32'(o.slice_out),   32'd0);
        check({tag, " acc_en"},      32'(o.acc_en),      32'd0);
        check({tag, " done_valid"},  32'(o.done_valid),  32'd0);
    endtask

    // Expected outputs in cycle k after the accepting edge, derived from the timing rules.
    task automatic check_cycle(input int k, input logic sgn, input logic [W*N-1:0] es);
        bit           sv;
        int           b;
        logic [N-1:0] exp_s;
        sv    = (k >= 1) && (k <= W);
        b     = W - k;
        exp_s = sv ? es[b*N +: N] : '0;
        check("slice_valid", 32'(o.slice_valid), 32'(sv));
        check("slice_out",   32'(o.slice_out),   32'(exp_s));
        if (sv) check("bit_idx", 32'(o.bit_idx), 32'(b));
        check("acc_en",      32'(o.acc_en),      32'((k >= 1 + lat) && (k <= W + lat)));
        check("acc_clear",   32'(o.acc_clear),   32'(k == 1 + lat));
        check("acc_neg",     32'(o.acc_neg),     32'((k == 1 + lat) && sgn));
        check("acc_last",    32'(o.acc_last),    32'(k == W + lat));
        check("done_valid",  32'(o.done_valid),  32'(k >= W + lat + 1));
        check("busy",        32'(o.busy),        32'd1);
        check("start_ready", 32'(o.start_ready), 32'd0);
    endtask

    task automatic accept(input logic [N*W-1:0] a, input logic sgn);
        check("accept start_ready", 32'(o.start_ready), 32'd1);
        start_valid = 1'b1;
        act_in      = a;
        act_signed  = sgn;
        tick();
        start_valid = 1'b0;
        act_in      = {$urandom(), $urandom(), $urandom(), $urandom()};
        act_signed  = ~sgn;
        got_result  = 1'b0;
    endtask

    // Entered in cycle 1 of a vector; runs it through DONE (holding done_ready low `hold` cycles) to IDLE.
    task automatic run_from_accept(input logic [N*W-1:0] a, input logic sgn,
                                   input logic [W*N-1:0] es, input int hold);
        for (int k = 1; k <= W + lat; k++) begin
            check_cycle(k, sgn, es);
            tick();
        end
        check_cycle(W + lat + 1, sgn, es);
        for (int h = 0; h < hold; h++) begin
            tick();
            check_cycle(W + lat + 1, sgn, es);
        end
        check("result produced", 32'(got_result), 32'd1);
        check("dot product", 32'(acc_result), 32'(golden(a, sgn)));
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
        check_idle("handoff");
    endtask

    task automatic abort_at(input int k, input logic with_ready);
        logic [N*W-1:0] a;
        a = {$urandom(), $urandom(), $urandom(), $urandom()};
        accept(a, 1'b0);
        for (int c = 1; c < k; c++) tick();
        abort      = 1'b1;
        done_ready = with_ready;
        tick();
        abort      = 1'b0;
        done_ready = 1'b0;
        for (int j = 0; j < W + 4; j++) begin
            check_idle("after abort");
            tick();
        end
    endtask

    task automatic run_suite();
        logic [N*W-1:0] a, b;
        logic           s;

        for (int r = 0; r < N; r++) w[r] = int'($urandom_range(0, 15)) - 8;
        foreach (tbl[i]) begin
            accept(tbl[i].act, tbl[i].sgn);
            run_from_accept(tbl[i].act, tbl[i].sgn, tbl[i].exp_slices, 0);
        end

        for (int i = 0; i < 6; i++) begin
            for (int r = 0; r < N; r++) w[r] = int'($urandom_range(0, 15)) - 8;
            a = {$urandom(), $urandom(), $urandom(), $urandom()};
            s = 1'($urandom_range(0, 1));
            accept(a, s);
            run_from_accept(a, s, pack_slices(a), 0);
        end

        // Backpressure: result held 5 cycles while a new vector waits, then back-to-back accept.
        a = {$urandom(), $urandom(), $urandom(), $urandom()};
        b = {$urandom(), $urandom(), $urandom(), $urandom()};
        accept(a, 1'b0);
        start_valid = 1'b1;
        act_in      = b;
        act_signed  = 1'b1;
        run_from_accept(a, 1'b0, pack_slices(a), 5);
        tick();
        start_valid = 1'b0;
        act_in      = '0;
        got_result  = 1'b0;
        run_from_accept(b, 1'b1, pack_slices(b), 0);

        abort_at(5, 1'b0);            // STREAM at bit_idx 3
        abort_at(W + 1, 1'b0);        // first DRAIN cycle
        abort_at(W + lat + 1, 1'b1);  // DONE with done_ready in the same cycle

        // Reset mid-STREAM at bit_idx 5.
        a = {$urandom(), $urandom(), $urandom(), $urandom()};
        accept(a, 1'b0);
        tick();
        tick();
        check("pre-reset bit_idx", 32'(o.bit_idx), 32'd5);
        set_rst(1'b1);
        #1;
        check_idle("async reset");
        check("async reset bit_idx", 32'(o.bit_idx), 32'd0);
        check("async reset acc_last", 32'(o.acc_last), 32'd0);
        tick();
        tick();
        set_rst(1'b0);
        tick();
        check_idle("after reset");
        accept(a, 1'b1);
        run_from_accept(a, 1'b1, pack_slices(a), 0);
    endtask

    initial begin
        tbl[0] = '{act: {16{8'hA5}}, sgn: 1'b0,
                   exp_slices: 128'hFFFF_0000_FFFF_0000_0000_FFFF_0000_FFFF};
        tbl[1] = '{act: 128'h80, sgn: 1'b1,
                   exp_slices: 128'h0001_0000_0000_0000_0000_0000_0000_0000};
        tbl[2] = '{act: 128'h80, sgn: 1'b0,
                   exp_slices: 128'h0001_0000_0000_0000_0000_0000_0000_0000};
        tbl[3] = '{act: 128'h0F0E0D0C_0B0A0908_07060504_03020100, sgn: 1'b1,
                   exp_slices: 128'h0000_0000_0000_0000_FF00_F0F0_CCCC_AAAA};
        tbl[4] = '{act: {8'h01, {15{8'h7F}}}, sgn: 1'b1,
                   exp_slices: 128'h0000_7FFF_7FFF_7FFF_7FFF_7FFF_7FFF_FFFF};

        sel         = 1'b0;
        lat         = 1;
        rst1        = 1'b1;
        rst3        = 1'b1;
        start_valid = 1'b0;
        act_signed  = 1'b0;
        abort       = 1'b0;
        done_ready  = 1'b0;
        act_in      = '0;
        got_result  = 1'b0;
        acc_result  = 0;
        model_reset();

        tick();
        tick();
        check_idle("in reset");
        check("in reset bit_idx", 32'(o.bit_idx), 32'd0);
        rst1 = 1'b0;
        tick();
        check_idle("reset release");
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle("abort in idle");
        run_suite();

        rst1 = 1'b1;
        sel  = 1'b1;
        lat  = 3;
        tick();
        rst3 = 1'b0;
        model_reset();
        tick();
        check_idle("lat3 reset release");
        run_suite();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
